// File: rtl/image_line_streamer.sv
// Frame RAM plus AXI4-Stream line master paced by line-buffer interrupts.
// Ports: axi_clk/axi_reset_n, i_wr_* frame load, i_start/i_intr control,
//   o_data*/i_data_ready AXIS master, o_busy/o_done status.
module image_line_streamer #(
  parameter int INTEGER_BITS     = 8,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_WIDTH        = 512,
  parameter int IMG_HEIGHT       = 512,
  parameter int PRELOAD_LINES    = 4,
  parameter int ADDR_WIDTH       = 18
) (
  input  logic                                     axi_clk,
  input  logic                                     axi_reset_n,
  input  logic                                     i_wr_en,
  input  logic [ADDR_WIDTH-1:0]                    i_wr_addr,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] i_wr_data,
  input  logic                                     i_start,
  input  logic                                     i_intr,
  output logic                                     o_data_valid,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_data,
  output logic                                     o_data_last,
  input  logic                                     i_data_ready,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int DW    = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int PRE_N = (PRELOAD_LINES < IMG_HEIGHT) ?
                         PRELOAD_LINES : IMG_HEIGHT;
  localparam int XW    = $clog2(IMG_WIDTH + 1);
  localparam int LW    = $clog2(IMG_HEIGHT + 1);
  localparam int CW    = $clog2(IMG_HEIGHT) + 1;
  localparam int AW1   = ADDR_WIDTH + 1;

  localparam logic [XW-1:0]         COL_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0]         X_ONE     = XW'(1);
  localparam logic [LW-1:0]         LINE_LAST = LW'(IMG_HEIGHT - 1);
  localparam logic [LW-1:0]         PRE_INIT  = LW'(PRE_N);
  localparam logic [LW-1:0]         L_ONE     = LW'(1);
  localparam logic [CW-1:0]         CRED_MAX  = CW'(IMG_HEIGHT);
  localparam logic [CW-1:0]         C_ONE     = CW'(1);
  localparam logic [AW1-1:0]        NPIX_A    = AW1'(NPIX);
  localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_WAIT_INTR,
    S_LINE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // interrupt synchroniser / edge detect and credit pool
  logic          r_intr;
  logic          r_intr_d;
  logic [CW-1:0] r_credit;

  // handshake side: position of the pixel at the stream head
  logic [LW-1:0] r_line;
  logic [XW-1:0] r_col;
  logic [LW-1:0] r_pre_left;

  // fetch side: next RAM read and lines still cleared to fetch
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [XW-1:0]         r_icol;
  logic [LW-1:0]         r_iss_lines;

  // RAM read register and 2-entry output buffer
  logic [DW-1:0] r_mem [2**ADDR_WIDTH];
  logic [DW-1:0] r_q;
  logic          r_q_valid;
  logic [DW-1:0] r_fd [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;

  logic       w_busy;
  logic       w_start;
  logic       w_valid;
  logic       w_pop;
  logic       w_last_hs;
  logic       w_intr_edge;
  logic       w_take;
  logic       w_issue;
  logic       w_issue_eol;
  logic       w_wr;
  logic [2:0] w_occ;

  assign w_busy = (r_state == S_PRELOAD) ||
                  (r_state == S_WAIT_INTR) ||
                  (r_state == S_LINE);

  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_valid     = (r_cnt != 2'd0);
  assign w_pop       = w_valid && i_data_ready;
  assign w_last_hs   = w_pop && (r_col == COL_LAST);
  assign w_intr_edge = r_intr && !r_intr_d && w_busy;
  assign w_take      = (r_state == S_WAIT_INTR) &&
                       (r_credit != '0);

  assign w_wr = i_wr_en && !w_busy &&
                ({1'b0, i_wr_addr} < NPIX_A);

  // Occupancy the buffer will have after this edge. Fetching
  // whenever it is below two keeps at most two words queued
  // once the in-flight RAM read lands, yet streams 1 pixel/clk.
  assign w_occ = {1'b0, r_cnt} + {2'b00, r_q_valid} -
                 {2'b00, w_pop};

  assign w_issue     = (r_iss_lines != '0) && (w_occ < 3'd2);
  assign w_issue_eol = w_issue && (r_icol == COL_LAST);

  assign o_data_valid = w_valid;
  assign o_data       = r_fd[r_rp];
  assign o_data_last  = w_valid && (r_col == COL_LAST);
  assign o_busy       = w_busy;
  assign o_done       = (r_state == S_DONE);

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (PRE_N == 0) ? S_WAIT_INTR : S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        if (w_last_hs && (r_pre_left == L_ONE)) begin
          w_state_nxt = (r_line == LINE_LAST) ?
                        S_DONE : S_WAIT_INTR;
        end
      end
      S_WAIT_INTR: begin
        if (w_take) begin
          w_state_nxt = S_LINE;
        end
      end
      S_LINE: begin
        if (w_last_hs) begin
          w_state_nxt = (r_line == LINE_LAST) ?
                        S_DONE : S_WAIT_INTR;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_intr   <= 1'b0;
      r_intr_d <= 1'b0;
      r_credit <= '0;
    end else begin
      r_intr   <= i_intr;
      r_intr_d <= r_intr;
      if (w_start) begin
        r_credit <= '0;
      end else if (w_take && !w_intr_edge) begin
        r_credit <= r_credit - C_ONE;
      end else if (!w_take && w_intr_edge &&
                   (r_credit != CRED_MAX)) begin
        r_credit <= r_credit + C_ONE;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_line     <= '0;
      r_col      <= '0;
      r_pre_left <= '0;
    end else if (w_start) begin
      r_line     <= '0;
      r_col      <= '0;
      r_pre_left <= PRE_INIT;
    end else if (w_pop) begin
      if (r_col == COL_LAST) begin
        r_col  <= '0;
        r_line <= r_line + L_ONE;
        if ((r_state == S_PRELOAD) && (r_pre_left != '0)) begin
          r_pre_left <= r_pre_left - L_ONE;
        end
      end else begin
        r_col <= r_col + X_ONE;
      end
    end
  end

  // A line grant (start or credit) lets the fetcher run ahead of
  // the handshake side; it stops at the end of each granted line.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_rd_addr   <= '0;
      r_icol      <= '0;
      r_iss_lines <= '0;
    end else if (w_start) begin
      r_rd_addr   <= '0;
      r_icol      <= '0;
      r_iss_lines <= PRE_INIT;
    end else begin
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + A_ONE;
        r_icol    <= w_issue_eol ? '0 : r_icol + X_ONE;
      end
      r_iss_lines <= r_iss_lines + LW'(w_take) -
                     LW'(w_issue_eol);
    end
  end

  // frame RAM: contents survive reset
  always_ff @(posedge axi_clk) begin
    if (w_wr) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (w_issue) begin
      r_q <= r_mem[r_rd_addr];
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      r_q_valid <= 1'b0;
      r_fd[0]   <= '0;
      r_fd[1]   <= '0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      r_q_valid <= w_issue;
      if (r_q_valid) begin
        r_fd[r_wp] <= r_q;
        r_wp       <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, r_q_valid} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_image_line_streamer.sv
// Bench: two streamers (6-line and 2-line frames) checked
// against a transaction-level model of the pixel stream.
module tb_image_line_streamer;

  localparam int W    = 4;
  localparam int NP_A = 24;
  localparam int NP_B = 8;

  logic        clk;
  logic        rst_n   [2];
  logic        wr_en   [2];
  logic [4:0]  wr_addr [2];
  logic [11:0] wr_data [2];
  logic        start   [2];
  logic        intr    [2];
  logic        v       [2];
  logic [11:0] data    [2];
  logic        last    [2];
  logic        ready   [2];
  logic        busy    [2];
  logic        done    [2];

  int n_tests = 0;
  int n_fail  = 0;

  image_line_streamer #(
    .INTEGER_BITS(8), .FIXED_POINT_BITS(4),
    .IMG_WIDTH(4), .IMG_HEIGHT(6),
    .PRELOAD_LINES(4), .ADDR_WIDTH(5)
  ) u_a (
    .axi_clk(clk), .axi_reset_n(rst_n[0]),
    .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]),
    .i_wr_data(wr_data[0]), .i_start(start[0]),
    .i_intr(intr[0]), .o_data_valid(v[0]),
    .o_data(data[0]), .o_data_last(last[0]),
    .i_data_ready(ready[0]), .o_busy(busy[0]),
    .o_done(done[0])
  );

  image_line_streamer #(
    .INTEGER_BITS(8), .FIXED_POINT_BITS(4),
    .IMG_WIDTH(4), .IMG_HEIGHT(2),
    .PRELOAD_LINES(4), .ADDR_WIDTH(5)
  ) u_b (
    .axi_clk(clk), .axi_reset_n(rst_n[1]),
    .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]),
    .i_wr_data(wr_data[1]), .i_start(start[1]),
    .i_intr(intr[1]), .o_data_valid(v[1]),
    .o_data(data[1]), .o_data_last(last[1]),
    .i_data_ready(ready[1]), .o_busy(busy[1]),
    .o_done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d",
               nm, d, act, exp);
    end
  endtask

  // transaction model state
  logic [11:0] m_mem  [2][32];
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_hold [2];
  logic [11:0] m_hd   [2];
  logic        m_hl   [2];
  logic        m_iprev[2];
  int          m_idx  [2];
  int          m_allow[2];
  int          hs_cnt [2];
  int          done_cnt[2];
  int          first_dat[2];
  int          last_dat [2];
  logic        mon_en = 1'b0;
  logic        hs;
  logic        was_done;
  int          np;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        np = (d == 0) ? NP_A : NP_B;
        chk("busy", d, busy[d], m_busy[d]);
        chk("done", d, done[d], m_done[d]);
        if (m_hold[d]) begin
          chk("hold_valid", d, v[d], 1'b1);
          chk("hold_data", d, data[d], m_hd[d]);
          chk("hold_last", d, last[d], m_hl[d]);
        end
        if (!m_busy[d]) chk("idle_valid", d, v[d], 1'b0);
        hs = v[d] && ready[d] && rst_n[d];
        if (hs) begin
          if (m_idx[d] < np) begin
            chk("pix_data", d, data[d], m_mem[d][m_idx[d]]);
            chk("pix_last", d, last[d],
                (m_idx[d] % W) == W - 1);
            chk("credit_gate", d,
                (m_idx[d] / W) < m_allow[d], 1'b1);
          end else begin
            chk("overrun", d, m_idx[d], np - 1);
          end
        end
        if (done[d]) done_cnt[d]++;
        m_hold[d] = v[d] && !ready[d] && rst_n[d];
        m_hd[d]   = data[d];
        m_hl[d]   = last[d];
        was_done  = m_done[d];
        m_done[d] = 1'b0;
        if (wr_en[d] && rst_n[d] && !m_busy[d] &&
            (int'(wr_addr[d]) < np))
          m_mem[d][wr_addr[d]] = wr_data[d];
        if (rst_n[d] && intr[d] && !m_iprev[d] && m_busy[d])
          m_allow[d]++;
        m_iprev[d] = intr[d];
        if (!rst_n[d]) begin
          m_busy[d] = 1'b0;
          m_idx[d]  = 0;
          m_hold[d] = 1'b0;
        end else if (hs) begin
          if (m_idx[d] == 0) first_dat[d] = int'(data[d]);
          if (m_idx[d] == np - 1) last_dat[d] = int'(data[d]);
          m_idx[d]++;
          hs_cnt[d]++;
          if (m_idx[d] == np) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
          end
        end else if (!m_busy[d] && !was_done && start[d]) begin
          m_busy[d]  = 1'b1;
          m_idx[d]   = 0;
          m_allow[d] = (d == 0) ? 4 : 2;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int d, input int a, input int val);
    wr_en[d]   = 1'b1;
    wr_addr[d] = 5'(a);
    wr_data[d] = 12'(val);
    tick(1);
    wr_en[d]   = 1'b0;
  endtask

  task automatic go(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  task automatic pulse(input int d);
    intr[d] = 1'b1;
    tick(1);
    intr[d] = 1'b0;
  endtask

  task automatic wait_hs(input int d, input int n,
                         input int budget, input string nm);
    int c = 0;
    while (hs_cnt[d] < n && c < budget) begin
      tick(1);
      c++;
    end
    chk(nm, d, hs_cnt[d], n);
  endtask

  task automatic wait_done(input int d, input int budget,
                           input string nm);
    int c = 0;
    while (done_cnt[d] < 1 && c < budget) begin
      tick(1);
      c++;
    end
    chk(nm, d, done_cnt[d], 1);
  endtask

  task automatic clr(input int d);
    hs_cnt[d]   = 0;
    done_cnt[d] = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int rnd0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; wr_en[d] = 1'b0; wr_addr[d] = '0;
      wr_data[d] = '0; start[d] = 1'b0; intr[d] = 1'b0;
      ready[d] = 1'b1;
      m_busy[d] = 1'b0; m_done[d] = 1'b0; m_hold[d] = 1'b0;
      m_hd[d] = '0; m_hl[d] = 1'b0; m_iprev[d] = 1'b0;
      m_idx[d] = 0; m_allow[d] = 0; hs_cnt[d] = 0;
      done_cnt[d] = 0; first_dat[d] = -1; last_dat[d] = -1;
      for (int a = 0; a < 32; a++) m_mem[d][a] = '0;
    end
    tick(2);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, v[d], 1'b0);
      chk("rst_data", d, data[d], 12'd0);
      chk("rst_last", d, last[d], 1'b0);
      chk("rst_busy", d, busy[d], 1'b0);
      chk("rst_done", d, done[d], 1'b0);
    end
    mon_en = 1'b1;
    tick(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // preload: pixels 0..15 back to back, 2 cycles after start
    for (int a = 0; a < NP_A; a++) wr(0, a, a);
    wr(0, 28, 12'h5a5);
    go(0);
    @(negedge clk); chk("lat_n0", 0, v[0], 1'b0);
    @(negedge clk); chk("lat_n1", 0, v[0], 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("pre_valid", 0, v[0], 1'b1);
      chk("pre_data", 0, data[0], k);
      chk("pre_last", 0, last[0], (k % 4) == 3);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("wait_valid", 0, v[0], 1'b0);
      chk("wait_busy", 0, busy[0], 1'b1);
    end
    tick(1);

    // one line per interrupt
    pulse(0);
    wait_hs(0, 20, 30, "line4");
    tick(20);
    chk("no_credit_hold", 0, hs_cnt[0], 20);
    pulse(0);
    wait_done(0, 40, "done1");
    tick(3);
    chk("frame1_pix", 0, hs_cnt[0], 24);
    chk("frame1_done", 0, done_cnt[0], 1);
    chk("last_pix", 0, last_dat[0], 23);
    @(negedge clk); chk("idle_busy", 0, busy[0], 1'b0);
    tick(1);

    // credits banked during preload; start while busy ignored
    clr(0);
    go(0);
    tick(3);
    pulse(0);
    tick(3);
    go(0);
    pulse(0);
    wait_done(0, 100, "banked_done");
    tick(3);
    chk("banked_pix", 0, hs_cnt[0], 24);
    chk("banked_done_cnt", 0, done_cnt[0], 1);

    // random data, random backpressure
    for (int a = 0; a < NP_A; a++) begin
      int r;
      r = int'($urandom_range(0, 4095));
      if (a == 0) rnd0 = r;
      wr(0, a, r);
    end
    clr(0);
    go(0);
    for (int c = 0; c < 600 && done_cnt[0] < 1; c++) begin
      ready[0] = 1'($urandom_range(0, 1));
      intr[0]  = (c == 3) || (c == 7);
      tick(1);
    end
    ready[0] = 1'b1;
    intr[0]  = 1'b0;
    tick(3);
    chk("rand_pix", 0, hs_cnt[0], 24);
    chk("rand_done", 0, done_cnt[0], 1);

    // reset mid-line, then restart from pixel 0
    clr(0);
    go(0);
    wait_hs(0, 6, 20, "pre_reset_pix");
    rst_n[0] = 1'b0;
    tick(1);
    @(negedge clk);
    chk("mid_rst_valid", 0, v[0], 1'b0);
    chk("mid_rst_busy", 0, busy[0], 1'b0);
    tick(1);
    rst_n[0] = 1'b1;
    clr(0);
    first_dat[0] = -1;
    go(0);
    tick(4);
    pulse(0);
    tick(3);
    pulse(0);
    wait_done(0, 100, "restart_done");
    tick(3);
    chk("restart_pix", 0, hs_cnt[0], 24);
    chk("restart_first", 0, first_dat[0], rnd0);

    // 2-line frame: finishes inside preload
    for (int a = 0; a < NP_B; a++) wr(1, a, 100 + a);
    clr(1);
    go(1);
    wait_done(1, 30, "short_done");
    tick(3);
    chk("short_pix", 1, hs_cnt[1], 8);
    chk("short_first", 1, first_dat[1], 100);
    chk("short_last", 1, last_dat[1], 107);

    // writes while busy are dropped
    clr(1);
    go(1);
    tick(1);
    for (int a = 0; a < NP_B; a++) wr(1, a, 12'h0aa);
    wait_done(1, 30, "busywr_done");
    tick(3);
    clr(1);
    first_dat[1] = -1;
    last_dat[1]  = -1;
    go(1);
    wait_done(1, 30, "reread_done");
    tick(3);
    chk("reread_pix", 1, hs_cnt[1], 8);
    chk("reread_first", 1, first_dat[1], 100);
    chk("reread_last", 1, last_dat[1], 107);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_line_streamer.md
Name: image_line_streamer

Overview:
- AXI4-Stream master that stores one image frame in an internal RAM and streams it, line by line, into the image-processing top's slave pixel interface.
- Credit flow:
  - After a start, it preloads PRELOAD_LINES lines to fill the downstream line buffers.
  - It then sends exactly one further line per rising edge of the processing core's interrupt (one line buffer freed).
- It is the transmitting end of the pixel stream and the consumer of that interrupt.

Parameters:
- INTEGER_BITS, 8, integer bits per fixed-point pixel
- FIXED_POINT_BITS, 4, fractional bits per pixel
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- PRELOAD_LINES, 4, lines sent before waiting on interrupts
- ADDR_WIDTH, 18, RAM address width; must satisfy 2**ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT

Ports:
- axi_clk  in  1  clock
- axi_reset_n  in  1  synchronous active-low reset
- i_wr_en  in  1  frame RAM write strobe
- i_wr_addr  in  ADDR_WIDTH  write address, raster order (line*IMG_WIDTH+col)
- i_wr_data  in  INTEGER_BITS+FIXED_POINT_BITS  pixel to store
- i_start  in  1  begin streaming the stored frame
- i_intr  in  1  line-buffer-free interrupt from the processing core
- o_data_valid  out  1  AXIS tvalid
- o_data  out  INTEGER_BITS+FIXED_POINT_BITS  AXIS tdata
- o_data_last  out  1  AXIS tlast, high on the last pixel of each line
- i_data_ready  in  1  AXIS tready
- o_busy  out  1  high from start acceptance until the frame is complete
- o_done  out  1  one-cycle pulse when the final pixel handshake completes

Behaviour:
- Reset (axi_reset_n=0 at a rising edge):
  - State goes to IDLE; o_data_valid, o_data_last, o_busy and o_done go to 0; o_data goes to 0.
  - Credit counter, line counter and column counter go to 0; the skid buffer is emptied.
  - RAM contents are not cleared.
  - Reset mid-frame: o_data_valid is 0 after that edge; no partial line resumes.
- Frame RAM: single write port, single synchronous read port (1-cycle read latency).
- Writes:
  - Accepted only in IDLE or DONE; ignored while o_busy=1.
  - Addresses >= IMG_WIDTH*IMG_HEIGHT are ignored.
- Interrupt:
  - i_intr is registered; a rising edge (previous 0, current 1) adds one credit.
  - Credit counter width is clog2(IMG_HEIGHT)+1 and saturates at IMG_HEIGHT.
  - Edges are counted in every busy state, so an edge arriving mid-line is not lost.
  - Edges in IDLE are discarded.
- States:
  - IDLE:
    - i_start=1 moves to PRELOAD and sets o_busy.
    - Line counter=0; remaining preload = min(PRELOAD_LINES, IMG_HEIGHT).
  - PRELOAD:
    - Streams lines back-to-back.
    - After the last pixel of the last preload line: WAIT_INTR if lines remain, else DONE.
  - WAIT_INTR: if credit>0, decrement credit and go to LINE.
  - LINE:
    - Streams one line.
    - On its last pixel handshake: DONE if line counter reaches IMG_HEIGHT, else WAIT_INTR.
    - A credit that arrives during LINE still allows WAIT_INTR to leave on the next cycle.
  - DONE:
    - o_done pulses for exactly one cycle on entry; o_busy clears in the same cycle.
    - Next cycle go to IDLE.
    - i_start during DONE is ignored.
- i_start while busy is ignored.
- AXIS rules:
  - Once o_data_valid=1, o_data, o_data_last and o_data_valid stay stable until o_data_valid & i_data_ready.
  - A 2-entry skid/prefetch buffer is used, so with i_data_ready held high within a line o_data_valid stays high every cycle: one pixel per clock, no bubbles.
  - o_data_valid never depends combinationally on i_data_ready.
- Latency:
  - i_start sampled at edge N gives o_data_valid=1 after edge N+2.
  - For a line started from WAIT_INTR, the first pixel is valid 2 cycles after the edge that moves to LINE.
- Boundaries:
  - o_data_last=1 exactly when column=IMG_WIDTH-1.
  - Column wraps to 0 and line increments on each last-pixel handshake.
  - The read address wraps nowhere; it ends at IMG_WIDTH*IMG_HEIGHT-1.
  - i_data_ready low for any number of cycles stalls without loss or duplication.

Test Plan:
- Params IMG_WIDTH=4, IMG_HEIGHT=6, PRELOAD_LINES=4:
  - Load pixel=address, i_start, i_data_ready=1 -> 16 pixels 0..15 on 16 consecutive cycles, starting 2 cycles after start, tlast on 3, 7, 11, 15; then valid=0 and o_busy=1.
  - From the idle wait: pulse i_intr twice 20 cycles apart -> pixels 16..19 after the first pulse and 20..23 after the second; o_done pulses once after pixel 23; o_busy=0.
  - Two i_intr pulses during preload -> after preload, lines 4 and 5 stream without further interrupts; one o_done.
  - Random i_data_ready (50%) over a full frame -> all 24 pixels exactly once, in order, data stable while stalled.
- Reset mid-line:
  - axi_reset_n=0 after pixel 5 -> o_data_valid=0 next edge, o_busy=0.
  - New i_start -> restarts at pixel 0.
- IMG_HEIGHT=2, PRELOAD_LINES=4:
  - i_start -> 8 pixels, then o_done without any interrupt.
  - Writes with o_busy=1 leave RAM unchanged (verified by a second frame).
